// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response handshake plus the word-organised data memory
// bus of the load/store controller.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: byte-addressed RV32I loads/stores onto a word memory,
// splitting word-crossing accesses into two beats and merging the load data.
module lsu_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  lsu_mem_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, B0, B1, DONE, RESP} state_t;

  state_t            state;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              split_q;
  logic [3:0]        be_hi_q;
  logic [31:0]       wd_hi_q;
  logic [31:0]       lo_buf;

  logic [3:0]        size_m;
  logic [7:0]        be64;
  logic [31:0]       wmask;
  logic [63:0]       wd64;
  logic              split;
  logic              illegal;

  always_comb begin
    size_m = 4'b0000;
    case (bus.req_funct3[1:0])
      2'd0:    size_m = 4'b0001;
      2'd1:    size_m = 4'b0011;
      2'd2:    size_m = 4'b1111;
      default: size_m = 4'b0000;
    endcase
    be64    = {4'b0000, size_m} << bus.req_addr[1:0];
    wmask   = {{8{size_m[3]}}, {8{size_m[2]}}, {8{size_m[1]}}, {8{size_m[0]}}};
    wd64    = {32'b0, bus.req_wdata & wmask} << {bus.req_addr[1:0], 3'b000};
    split   = |be64[7:4];
    illegal = bus.req_we ? (bus.req_funct3 > 3'd2)
                         : ((bus.req_funct3 == 3'd3) || (bus.req_funct3 > 3'd5));
  end

  // Split loads hold beat 0 in lo_buf; beat 1 (or the only beat) arrives in DONE.
  logic [31:0] lo, hi, raw, ld;
  always_comb begin
    lo  = split_q ? lo_buf : bus.mem_rdata;
    hi  = split_q ? bus.mem_rdata : '0;
    raw = 32'({hi, lo} >> {off_q, 3'b000});
    case (funct3_q)
      3'd0:    ld = {{24{raw[7]}}, raw[7:0]};
      3'd1:    ld = {{16{raw[15]}}, raw[15:0]};
      3'd4:    ld = {24'b0, raw[7:0]};
      3'd5:    ld = {16'b0, raw[15:0]};
      default: ld = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (bus.req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= bus.req_we;
            funct3_q  <= bus.req_funct3;
            off_q     <= bus.req_addr[1:0];
            split_q   <= split;
            be_hi_q   <= be64[7:4];
            wd_hi_q   <= wd64[63:32];
            if (illegal || (split && !MISALIGN_EN)) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              resp_err  <= 1'b0;
              mem_en    <= 1'b1;
              mem_we    <= bus.req_we;
              mem_addr  <= bus.req_addr[ADDR_W-1:2];
              mem_be    <= be64[3:0];
              mem_wdata <= wd64[31:0];
              state     <= B0;
            end
          end
        end
        B0: begin
          if (split_q) begin
            mem_addr  <= mem_addr + {{(ADDR_W-3){1'b0}}, 1'b1};
            mem_be    <= be_hi_q;
            mem_wdata <= wd_hi_q;
            state     <= B1;
          end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            state     <= DONE;
          end
        end
        B1: begin
          lo_buf    <= bus.mem_rdata;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= '0;
          mem_wdata <= '0;
          state     <= DONE;
        end
        DONE: begin
          resp_rdata <= we_q ? '0 : ld;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_err;
  assign bus.resp_rdata = resp_rdata;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_be     = mem_be;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a byte-level memory model predicts beats
// and responses; independent monitors compare them against the DUT.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus();
  lsu_mem_ctrl_if #(.ADDR_W(32)) bus_b();

  lsu_mem_ctrl #(.ADDR_W(32), .MISALIGN_EN(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus));
  lsu_mem_ctrl #(.ADDR_W(32), .MISALIGN_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct packed {
    logic [29:0] word;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } beat_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] lat;
  } rsp_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int stall = 0;
  int en_b_cnt = 0;
  bit holding = 1'b0;
  rsp_t cur;
  beat_t beat_q[$];
  rsp_t rsp_q[$];
  logic [7:0] refmem[64];
  logic [31:0] mem[16];
  logic [31:0] mw;
  logic [29:0] exp_b_addr;
  logic [3:0] exp_b_be;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory behind the main DUT: synchronous read, byte-enabled write.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      mw = mem[bus.mem_addr[3:0]];
      for (int i = 0; i < 4; i++)
        if (bus.mem_we && bus.mem_be[i]) mw[8*i +: 8] = bus.mem_wdata[8*i +: 8];
      mem[bus.mem_addr[3:0]] <= mw;
      bus.mem_rdata <= mem[bus.mem_addr[3:0]];
    end
  end

  always @(posedge clk) if (bus_b.mem_en) en_b_cnt <= en_b_cnt + 1;

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n, w0, w1, a, k;
    logic illegal;
    logic [31:0] v;
    beat_t b;
    rsp_t r;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
    r.err = illegal;
    r.rdata = '0;
    r.lat = 32'd1;
    if (!illegal) begin
      w0 = int'(addr) / 4;
      w1 = (int'(addr) + n - 1) / 4;
      for (int w = w0; w <= w1; w++) begin
        b.word = 30'(w);
        b.be = '0;
        b.we = we;
        b.wd = '0;
        for (int i = 0; i < n; i++) begin
          a = int'(addr) + i;
          if (a / 4 == w) begin
            b.be[a % 4] = 1'b1;
            b.wd[8*(a % 4) +: 8] = wdata[8*i +: 8];
          end
        end
        beat_q.push_back(b);
      end
      if (we) begin
        for (int i = 0; i < n; i++) refmem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refmem[int'(addr) + i];
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        r.rdata = v;
      end
      r.lat = (w1 != w0) ? 32'd4 : 32'd3;
    end
    rsp_q.push_back(r);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
      bus.req_valid = 1'b0;
    end else begin
      acc_cyc = cyc + 1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((rsp_q.size() != 0 || holding) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (rsp_q.size() != 0 || holding) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", rsp_q.size());
    end
  endtask

  // Response monitor: pops the expectation on first sight, re-checks while held.
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else if (bus.resp_valid) begin
      if (!holding) begin
        if (rsp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: resp_valid=1, required 0");
        end else begin
          cur = rsp_q.pop_front();
          holding = 1'b1;
          chk("latency", 32'(cyc - acc_cyc + 1), cur.lat);
        end
      end
      if (holding) begin
        chk("resp_rdata", bus.resp_rdata, cur.rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(cur.err));
        chk("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
      end
    end
    if (bus.resp_valid && stall > 0) begin
      bus.resp_ready = 1'b0;
      stall--;
    end else begin
      bus.resp_ready = ($urandom_range(3) != 0);
    end
    if (!rst && bus.resp_valid && bus.resp_ready) holding = 1'b0;
  end

  // Memory-side monitor for the main DUT.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_en) begin
        if (beat_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: mem_en=1 addr=%h, required no access", bus.mem_addr);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("mem_addr", 32'(bus.mem_addr), 32'(b.word));
          chk("mem_be", 32'(bus.mem_be), 32'(b.be));
          chk("mem_we", 32'(bus.mem_we), 32'(b.we));
          chk("mem_wdata", bus.mem_wdata, b.wd);
        end
      end else begin
        chk("idle_be", 32'(bus.mem_be), 32'd0);
        chk("idle_wdata", bus.mem_wdata, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_b.mem_en) begin
        chk("b_mem_addr", 32'(bus_b.mem_addr), 32'(exp_b_addr));
        chk("b_mem_be", 32'(bus_b.mem_be), 32'(exp_b_be));
        chk("b_mem_we", 32'(bus_b.mem_we), 32'd0);
      end else begin
        chk("b_idle_be", 32'(bus_b.mem_be), 32'd0);
        chk("b_idle_wdata", bus_b.mem_wdata, 32'd0);
      end
    end
  end

  task automatic issue_b(input logic [2:0] f3, input logic [31:0] addr, input logic exp_err,
                         input logic [31:0] exp_rdata, input int exp_lat, input int exp_beats,
                         input logic [29:0] ea, input logic [3:0] ebe);
    int k, a, en0;
    exp_b_addr = ea;
    exp_b_be = ebe;
    en0 = en_b_cnt;
    @(negedge clk);
    bus_b.req_valid = 1'b1;
    bus_b.req_funct3 = f3;
    bus_b.req_addr = addr;
    k = 0;
    while (!bus_b.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    a = cyc + 1;
    @(posedge clk);
    #1 bus_b.req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!bus_b.resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b_latency", 32'(cyc - a + 1), 32'(exp_lat));
    chk("b_resp_err", 32'(bus_b.resp_err), 32'(exp_err));
    chk("b_resp_rdata", bus_b.resp_rdata, exp_rdata);
    chk("b_beats", 32'(en_b_cnt - en0), 32'(exp_beats));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    bus.mem_rdata = '0;
    bus_b.req_valid = 1'b0;
    bus_b.req_we = 1'b0;
    bus_b.req_funct3 = '0;
    bus_b.req_addr = '0;
    bus_b.req_wdata = '0;
    bus_b.resp_ready = 1'b1;
    bus_b.mem_rdata = 32'h12345678;
    for (int w = 0; w < 16; w++) begin
      logic [31:0] v;
      v = (w == 0) ? 32'h11223344 : (w == 1) ? 32'h55667788 : (w == 2) ? 32'hA0B0C0D0 : $urandom;
      mem[w] = v;
      for (int i = 0; i < 4; i++) refmem[4*w + i] = v[8*i +: 8];
    end

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

    issue(1'b0, 3'd2, 32'd0, 32'd0);
    issue(1'b0, 3'd1, 32'd3, 32'd0);
    issue(1'b0, 3'd5, 32'd3, 32'd0);
    issue(1'b0, 3'd0, 32'd7, 32'd0);
    issue(1'b0, 3'd4, 32'd0, 32'd0);
    issue(1'b0, 3'd2, 32'd6, 32'd0);
    issue(1'b1, 3'd2, 32'd1, 32'hEDCF1254);
    issue(1'b0, 3'd2, 32'd1, 32'd0);
    issue(1'b1, 3'd1, 32'd2, 32'h00001254);
    issue(1'b0, 3'd3, 32'd0, 32'd0);
    issue(1'b1, 3'd5, 32'd8, 32'h0000FFFF);
    issue(1'b0, 3'd6, 32'd0, 32'd0);
    issue(1'b0, 3'd7, 32'd4, 32'd0);
    drain();

    stall = 3;
    issue(1'b0, 3'd2, 32'd8, 32'd0);
    drain();

    for (int t = 0; t < 300; t++)
      issue(1'($urandom_range(1)), 3'($urandom_range(7)), 32'($urandom_range(59)), $urandom);
    drain();

    // Reset in the second beat of a split load: no response, back to idle.
    issue(1'b0, 3'd2, 32'd6, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    #1 rst = 1'b0;
    rsp_q.delete();
    @(negedge clk);
    chk("midrst_req_ready_up", 32'(bus.req_ready), 32'd1);
    chk("midrst_beats_left", 32'(beat_q.size()), 32'd0);
    issue(1'b0, 3'd2, 32'd4, 32'd0);
    drain();

    issue_b(3'd2, 32'd2, 1'b1, 32'd0, 1, 0, 30'd0, 4'b0000);
    issue_b(3'd1, 32'd3, 1'b1, 32'd0, 1, 0, 30'd0, 4'b0000);
    issue_b(3'd2, 32'd4, 1'b0, 32'h12345678, 3, 1, 30'd1, 4'b1111);
    issue_b(3'd1, 32'd1, 1'b0, 32'h00003456, 3, 1, 30'd0, 4'b0110);

    chk("beats_left", 32'(beat_q.size()), 32'd0);
    chk("resp_left", 32'(rsp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
